fetch_ctrl: RTL
===============

# fetch_ctrl

Fetch controller that sequences instruction fetch into the instruction buffer. It tracks the fetch PC and issues one 8-byte-aligned block request at a time to the I-cache. It unpacks each returned block into up to `N` `FETCH_PACKET`s, limited by the free spots the instruction buffer reports. On a branch-stack restore it redirects the PC and discards stale in-flight data.

## Interface
Parameters:
- `RESET_PC`, default `32'h0`: fetch PC loaded on reset.
- Superscalar width comes from the shared `` `N `` macro, not a module parameter.

Ports:
- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `inst_buffer_spots`  in  `` `NUM_SCALAR_BITS ``  free instruction-buffer slots this cycle, 0..`N`.
- `restore_valid`  in  1  branch-stack redirect.
- `restore_pc`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `icache_req_valid`  out  1  block request valid.
- `icache_req_addr`  out  32  block address, `{pc[31:3],3'b0}`.
- `icache_req_ready`  in  1  cache accepts the request this cycle.
- `icache_rsp_valid`  in  1  block data returned; in order, one per accepted request.
- `icache_rsp_data`  in  64  word0 = bits [31:0] (addr+0), word1 = bits [63:32] (addr+4).
- `fetch_packets`  out  `FETCH_PACKET [`N-1:0]`  packets to the instruction buffer, oldest first.
- `fetch_valid`  out  `` `NUM_SCALAR_BITS ``  count of valid packets, 0..`N`.

## Operation
- States: `REQ`, `WAIT`, `HOLD`, `SQUASH`. Registers: `pc`, `block_q` (64 bits), `state`.
- At most one request is outstanding.
- **REQ**
  - `icache_req_valid = 1`.
  - On `restore_valid`: `pc <= restore_pc`, stay in REQ. This takes priority over the handshake; a same-cycle ready is treated as not accepted.
  - Else, if `icache_req_ready`, go to WAIT.
- **WAIT**
  - On `restore_valid` with `icache_rsp_valid` in the same cycle: drop the data, `pc <= restore_pc`, go to REQ.
  - On `restore_valid` without a response: `pc <= restore_pc`, go to SQUASH.
  - Else, if `icache_rsp_valid`: `block_q <= icache_rsp_data`, go to HOLD.
- **SQUASH**
  - Waits for the orphaned response and discards it, then goes to REQ.
  - A further `restore_valid` overwrites `pc` and the state stays SQUASH, unless a response arrives the same cycle, in which case go to REQ.
- **HOLD**
  - `rem = 2 - pc[2]` (1 or 2). `k = min(rem, inst_buffer_spots, N)`.
  - Packet i, for i < k: `.inst = block_q` word `(pc[2]+i)`, `.PC = pc + 4i`, `.NPC = .PC + 4`.
  - Packets i ≥ k are all-zero. `fetch_valid = k`.
  - Update `pc <= pc + 4k`. If `k == rem`, go to REQ; else stay in HOLD (this covers a stall when spots = 0).
  - On `restore_valid`: `fetch_valid = 0`, `pc <= restore_pc`, go to REQ.
- `fetch_valid` is 0 in every state except HOLD, and always 0 in any cycle with `restore_valid`. The instruction buffer flushes on restore, so packets issued in that cycle would be misplaced.
- PC arithmetic is 32-bit and wraps modulo 2^32.

## Timing
- While `reset` is high: all outputs are 0. On the next edge, `state = REQ`, `pc = RESET_PC`, `block_q = 0`.
- `icache_req_valid` is 1 in the first cycle after reset deasserts.
- Best-case latency:
  - Request accepted in cycle t.
  - With a 1-cycle cache, the response arrives in t+1.
  - Packets are issued in t+2 (HOLD).
  - The next request issues in t+3.
- Redirect: the first request to `restore_pc` is in the cycle after `restore_valid`, or in the cycle after the orphaned response if one was outstanding.
- All outputs are combinational from `state`, `pc`, `block_q` and the current-cycle inputs `inst_buffer_spots` and `restore_valid`. There are no other input-to-output paths.
- Reset mid-operation discards any outstanding request. The I-cache is reset by the same signal.

## Structure
- The shared package (`sys_defs.svh`) holds:
  - `FETCH_PACKET` (fields `inst`, `PC`, `NPC`), `` `N `` and `` `NUM_SCALAR_BITS ``.
  - A new `FETCH_STATE` enum (`REQ`, `WAIT`, `HOLD`, `SQUASH`).
- Implementation is a single flat module; block unpacking is a short loop, so no sub-module is warranted.

## Test plan
Run with `N=2`, `RESET_PC=0` unless stated.
- Reset, ready=1, 1-cycle cache, spots=2:
  - Requests go to 0x0, 0x8, 0x10.
  - Each HOLD emits `fetch_valid=2` with PCs {0,4}, {8,C}, {10,14}, NPC = PC+4.
- `restore_pc=0x104` while in REQ:
  - The next request address is 0x100.
  - HOLD emits `fetch_valid=1` with PC=0x104 (upper word only), then requests 0x108.
- Spots sequence 0, 1, 2 during HOLD of block 0x20:
  - `fetch_valid` is 0, then 1 (PC 0x20), then 1 (PC 0x24).
  - Exactly one request for 0x28 follows.
- `restore_valid` in WAIT with the response 3 cycles later:
  - State is SQUASH; the stale data is never emitted.
  - The request to `restore_pc` issues the cycle after the response.
- `restore_valid` coincident with `icache_rsp_valid` in WAIT, and again in HOLD with spots=2:
  - `fetch_valid=0` in both restore cycles.
  - The next request is to the new PC.
- `reset` asserted in HOLD and in SQUASH: all outputs are 0; a request to `RESET_PC` follows deassertion.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-side types: fetch packet layout, fetch FSM states and superscalar width macros.
// The width macros are guarded so a project-wide definition takes precedence.
`ifndef N
`define N 2
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 2
`endif

package fetch_ctrl_pkg;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
    } FETCH_PACKET;

    typedef enum logic [1:0] {
        REQ    = 2'd0,
        WAIT   = 2'd1,
        HOLD   = 2'd2,
        SQUASH = 2'd3
    } FETCH_STATE;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch controller: one outstanding 8-byte block request to the I-cache, unpacks the
// returned block into up to `N packets bounded by free instruction-buffer slots.
`ifndef N
`define N 2
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 2
`endif

module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [`NUM_SCALAR_BITS-1:0]   inst_buffer_spots,
    input  logic                          restore_valid,
    input  logic [31:0]                   restore_pc,
    output logic                          icache_req_valid,
    output logic [31:0]                   icache_req_addr,
    input  logic                          icache_req_ready,
    input  logic                          icache_rsp_valid,
    input  logic [63:0]                   icache_rsp_data,
    output FETCH_PACKET [`N-1:0]          fetch_packets,
    output logic [`NUM_SCALAR_BITS-1:0]   fetch_valid
);

    localparam logic [31:0] LANES = 32'(`N);

    FETCH_STATE                   state_r;
    FETCH_STATE                   next_state_s;
    logic [31:0]                  pc_r;
    logic [31:0]                  pc_next_s;
    logic [63:0]                  block_r;
    logic [63:0]                  block_next_s;
    logic [31:0]                  target_s;
    logic [31:0]                  rem_s;
    logic [31:0]                  spots_s;
    logic [31:0]                  lim_s;
    logic [31:0]                  k_s;
    logic                         req_valid_s;
    FETCH_PACKET [`N-1:0]         packets_s;
    logic [`NUM_SCALAR_BITS-1:0]  fetch_valid_s;

    // Redirect target is word aligned regardless of the low bits supplied.
    assign target_s = restore_pc & 32'hFFFF_FFFC;

    // Packets deliverable this cycle: words left in the block, capped by slots and lanes.
    always_comb begin
        rem_s   = pc_r[2] ? 32'd1 : 32'd2;
        spots_s = 32'(inst_buffer_spots);
        if (spots_s < rem_s) begin
            lim_s = spots_s;
        end else begin
            lim_s = rem_s;
        end
        if (lim_s < LANES) begin
            k_s = lim_s;
        end else begin
            k_s = LANES;
        end
    end

    // Next-state, PC/block update and packet generation.
    always_comb begin
        next_state_s  = state_r;
        pc_next_s     = pc_r;
        block_next_s  = block_r;
        req_valid_s   = 1'b0;
        packets_s     = '0;
        fetch_valid_s = '0;
        case (state_r)
            REQ: begin
                req_valid_s = 1'b1;
                if (restore_valid) begin
                    pc_next_s = target_s;
                end else if (icache_req_ready) begin
                    next_state_s = WAIT;
                end else begin
                    next_state_s = REQ;
                end
            end
            WAIT: begin
                if (restore_valid) begin
                    pc_next_s = target_s;
                    if (icache_rsp_valid) begin
                        next_state_s = REQ;
                    end else begin
                        next_state_s = SQUASH;
                    end
                end else if (icache_rsp_valid) begin
                    block_next_s = icache_rsp_data;
                    next_state_s = HOLD;
                end else begin
                    next_state_s = WAIT;
                end
            end
            SQUASH: begin
                if (restore_valid) begin
                    pc_next_s = target_s;
                end else begin
                    pc_next_s = pc_r;
                end
                if (icache_rsp_valid) begin
                    next_state_s = REQ;
                end else begin
                    next_state_s = SQUASH;
                end
            end
            HOLD: begin
                // Packets issued alongside a restore would land in a flushed buffer.
                if (restore_valid) begin
                    pc_next_s    = target_s;
                    next_state_s = REQ;
                end else begin
                    fetch_valid_s = k_s[`NUM_SCALAR_BITS-1:0];
                    for (int i = 0; i < `N; i++) begin
                        if (32'(i) < k_s) begin
                            packets_s[i].inst = (pc_r[2] || (i != 0)) ? block_r[63:32] : block_r[31:0];
                            packets_s[i].PC   = pc_r + 32'(4 * i);
                            packets_s[i].NPC  = pc_r + 32'(4 * i) + 32'd4;
                        end else begin
                            packets_s[i] = '0;
                        end
                    end
                    pc_next_s = pc_r + (k_s << 2);
                    if (k_s == rem_s) begin
                        next_state_s = REQ;
                    end else begin
                        next_state_s = HOLD;
                    end
                end
            end
            default: begin
                next_state_s = REQ;
            end
        endcase
    end

    // State, PC and block registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= REQ;
            pc_r    <= RESET_PC;
            block_r <= 64'h0;
        end else begin
            state_r <= next_state_s;
            pc_r    <= pc_next_s;
            block_r <= block_next_s;
        end
    end

    assign icache_req_valid = reset ? 1'b0  : req_valid_s;
    assign icache_req_addr  = reset ? 32'h0 : {pc_r[31:3], 3'b000};
    assign fetch_packets    = reset ? '0    : packets_s;
    assign fetch_valid      = reset ? '0    : fetch_valid_s;

endmodule
